execute_stage: RTL
==================

// Module: execute_stage
// PURPOSE
// - Execute stage of the RV32I pipeline, directly downstream of the fetch/decode pair.
// - Consumes the decoded opcode, ALU op, funct3, imm, register addresses and register-file
//   read data; computes ALU result, load/store address and branch/jump outcome.
// - Registers results into the EX/MEM boundary. Forwards its own last result to the next
//   instruction, requests a load-use stall, and redirects fetch on taken control flow.
// PARAMETERS
// - DWIDTH       32  data/operand width
// - AWIDTH       5   register address width
// - PC_WIDTH     32  program counter width
// - FUNCT_WIDTH  3   funct3 width
// PORTS
// - c_clk             in   1                clock, rising edge
// - c_rst             in   1                reset, asynchronous, active-high
// - ex_i_ce           in   1                stage enable; no capture when 0
// - ex_i_stall        in   1                downstream stall; hold all output registers
// - ex_i_flush        in   1                external flush; squash the incoming instruction
// - ex_i_valid        in   1                decode output holds a real instruction
// - ex_i_pc           in   PC_WIDTH         PC of the incoming instruction
// - ex_i_opcode       in   `OPCODE_WIDTH    decoded opcode
// - ex_i_alu          in   `ALU_WIDTH       decoded ALU operation
// - ex_i_funct3       in   FUNCT_WIDTH      funct3 (branch condition, load/store size)
// - ex_i_imm          in   DWIDTH           sign-extended immediate
// - ex_i_addr_rd      in   AWIDTH           destination register
// - ex_i_addr_rs1/rs2 in   AWIDTH           source register addresses
// - ex_i_rs1/rs2      in   DWIDTH           register-file read data
// - ex_o_valid        out  1                EX/MEM holds a valid instruction
// - ex_o_result       out  DWIDTH           ALU result / memory address / link value (pc+4)
// - ex_o_store_data   out  DWIDTH           forwarded rs2 value for stores
// - ex_o_addr_rd      out  AWIDTH           destination register
// - ex_o_we           out  1                register write-back required (rd != 0)
// - ex_o_opcode       out  `OPCODE_WIDTH    opcode passed to MEM
// - ex_o_funct3       out  FUNCT_WIDTH      funct3 passed to MEM
// - ex_o_change_pc    out  1                one-cycle pulse: redirect fetch
// - ex_o_next_pc      out  PC_WIDTH         redirect target, valid while ex_o_change_pc=1
// - ex_o_stall_req    out  1                combinational load-use stall request to fetch/decode
// BEHAVIOUR
// - Reset: every output register and the forwarding record clear to 0, immediately on c_rst.
// - Latency: 1 cycle; inputs accepted at edge N appear on outputs after edge N.
// - Accept = ex_i_ce & ~ex_i_stall & ~ex_o_stall_req. Stall holds outputs and the
//   forwarding record; ex_o_change_pc still drops after 1 cycle (no repeated pulse).
// - Squash = ex_i_flush | ex_o_change_pc | ~ex_i_valid. On accept with squash: ex_o_valid=0,
//   ex_o_we=0, ex_o_change_pc=0; other fields don't-care. Flush beats stall.
// - Operand A: pc for AUIPC/JAL, 0 for LUI, else forwarded rs1. Operand B: rs2 for OP/BRANCH,
//   imm otherwise. All arithmetic mod 2^DWIDTH; shifts use B[4:0]; SRA sign-fills; SLT signed,
//   SLTU unsigned.
// - Forwarding: record {valid, rd, result} of the last accepted non-squashed instruction with
//   we=1. If the record matches rs1/rs2 (rd != 0), use the recorded result instead of reg data.
// - Load-use: record is a LOAD and matches rs1/rs2 of a valid input -> ex_o_stall_req=1 for
//   exactly one cycle; the next cycle inserts no bubble twice (hazard clears once record
//   passes to MEM and the input is re-presented with the register file updated).
// - Branch funct3: 000 BEQ,001 BNE,100 BLT,101 BGE,110 BLTU,111 BGEU; others never taken.
//   Taken: change_pc=1, next_pc=pc+imm. JAL: pc+imm; JALR: (rs1+imm)&~1; both result=pc+4.
// - Not-taken branch or any other opcode: change_pc=0. Branch/store: we=0.
// STRUCTURE
// - Shared header: opcode constants, ALU op codes (`ALU_ADD..`ALU_AND), `OPCODE_WIDTH,
//   `ALU_WIDTH, branch funct3 codes.
// - One sub-module: alu_unit (purely combinational op/A/B -> result, plus branch compare).
// - Forwarding mux, hazard detect and EX/MEM registers stay in execute_stage.
// TESTING
// - Reset mid-run: assert c_rst between edges -> all outputs 0 at once, before next edge.
// - ADDI x1,x0,5 then ADD x2,x1,x1 (rs1 data stale 0) -> x2 result 10 via forwarding.
// - SUB 3-5 -> 0xFFFFFFFE; SRA 0x80000000>>>4 -> 0xF8000000; SLTU 1,-1 -> 1, SLT -> 0.
// - BEQ pc=0x10 imm=8 equal operands -> change_pc 1 cycle, next_pc 0x18, next input squashed.
// - JALR pc=0x20 rs1=0x103 imm=0 -> next_pc 0x102, result 0x24, we=1.
// - LW x3 then ADD x4,x3,x0 -> stall_req=1 one cycle; ex_i_stall=1 -> outputs held;
//   ex_i_flush=1 with valid ADD -> ex_o_valid=0, ex_o_we=0.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared opcode, ALU and branch encodings plus EX/MEM payload types for the execute stage.
package execute_stage_pkg;

    localparam int unsigned DWIDTH       = 32;
    localparam int unsigned AWIDTH       = 5;
    localparam int unsigned PC_WIDTH     = 32;
    localparam int unsigned FUNCT_WIDTH  = 3;
    localparam int unsigned OPCODE_WIDTH = 7;
    localparam int unsigned ALU_WIDTH    = 4;
    localparam int unsigned SHAMT_WIDTH  = 5;

    // RV32I major opcodes as delivered by decode
    localparam logic [OPCODE_WIDTH-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_OP     = 7'b0110011;

    // ALU operation codes
    localparam logic [ALU_WIDTH-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_WIDTH-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_WIDTH-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_WIDTH-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_WIDTH-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_WIDTH-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_WIDTH-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_WIDTH-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_WIDTH-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_WIDTH-1:0] ALU_AND  = 4'd9;

    // Branch conditions carried in funct3
    localparam logic [FUNCT_WIDTH-1:0] F3_BEQ  = 3'b000;
    localparam logic [FUNCT_WIDTH-1:0] F3_BNE  = 3'b001;
    localparam logic [FUNCT_WIDTH-1:0] F3_BLT  = 3'b100;
    localparam logic [FUNCT_WIDTH-1:0] F3_BGE  = 3'b101;
    localparam logic [FUNCT_WIDTH-1:0] F3_BLTU = 3'b110;
    localparam logic [FUNCT_WIDTH-1:0] F3_BGEU = 3'b111;

    // EX/MEM boundary payload
    typedef struct packed {
        logic                    valid;
        logic                    we;
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [FUNCT_WIDTH-1:0]  funct3;
        logic [AWIDTH-1:0]       addr_rd;
        logic [DWIDTH-1:0]       result;
        logic [DWIDTH-1:0]       store_data;
    } ex_mem_t;

    // Last register writer seen by this stage, used for forwarding and load-use detection
    typedef struct packed {
        logic              valid;
        logic              is_load;
        logic [AWIDTH-1:0] rd;
        logic [DWIDTH-1:0] result;
    } fwd_rec_t;

    // JAL and JALR write the link address rather than an ALU result
    function automatic logic is_link(input logic [OPCODE_WIDTH-1:0] opc);
        return (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/execute_stage_alu_unit.sv
// Combinational ALU and branch comparator for the execute stage.
module execute_stage_alu_unit
    import execute_stage_pkg::*;
(
    input  logic [ALU_WIDTH-1:0]   alu_op,
    input  logic [FUNCT_WIDTH-1:0] funct3,
    input  logic [DWIDTH-1:0]      op_a,
    input  logic [DWIDTH-1:0]      op_b,
    output logic [DWIDTH-1:0]      result_c,
    output logic                   br_taken_c
);

    logic [SHAMT_WIDTH-1:0] shamt;

    assign shamt = op_b[SHAMT_WIDTH-1:0];

    // Arithmetic/logic result, all wrapping modulo 2^DWIDTH
    always_comb begin
        result_c = '0;
        case (alu_op)
            ALU_ADD:  result_c = op_a + op_b;
            ALU_SUB:  result_c = op_a - op_b;
            ALU_SLL:  result_c = op_a << shamt;
            ALU_SLT:  result_c = DWIDTH'($signed(op_a) < $signed(op_b));
            ALU_SLTU: result_c = DWIDTH'(op_a < op_b);
            ALU_XOR:  result_c = op_a ^ op_b;
            ALU_SRL:  result_c = op_a >> shamt;
            ALU_SRA:  result_c = DWIDTH'($unsigned($signed(op_a) >>> shamt));
            ALU_OR:   result_c = op_a | op_b;
            ALU_AND:  result_c = op_a & op_b;
            default:  result_c = '0;
        endcase
    end

    // Branch condition on the two operands; unused funct3 codes never branch
    always_comb begin
        br_taken_c = 1'b0;
        case (funct3)
            F3_BEQ:  br_taken_c = (op_a == op_b);
            F3_BNE:  br_taken_c = (op_a != op_b);
            F3_BLT:  br_taken_c = ($signed(op_a) <  $signed(op_b));
            F3_BGE:  br_taken_c = ($signed(op_a) >= $signed(op_b));
            F3_BLTU: br_taken_c = (op_a <  op_b);
            F3_BGEU: br_taken_c = (op_a >= op_b);
            default: br_taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, load-use stall, ALU, control-flow redirect, EX/MEM register.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic                    c_clk,
    input  logic                    c_rst,
    input  logic                    ex_i_ce,
    input  logic                    ex_i_stall,
    input  logic                    ex_i_flush,
    input  logic                    ex_i_valid,
    input  logic [PC_WIDTH-1:0]     ex_i_pc,
    input  logic [OPCODE_WIDTH-1:0] ex_i_opcode,
    input  logic [ALU_WIDTH-1:0]    ex_i_alu,
    input  logic [FUNCT_WIDTH-1:0]  ex_i_funct3,
    input  logic [DWIDTH-1:0]       ex_i_imm,
    input  logic [AWIDTH-1:0]       ex_i_addr_rd,
    input  logic [AWIDTH-1:0]       ex_i_addr_rs1,
    input  logic [AWIDTH-1:0]       ex_i_addr_rs2,
    input  logic [DWIDTH-1:0]       ex_i_rs1,
    input  logic [DWIDTH-1:0]       ex_i_rs2,
    output logic                    ex_o_valid,
    output logic [DWIDTH-1:0]       ex_o_result,
    output logic [DWIDTH-1:0]       ex_o_store_data,
    output logic [AWIDTH-1:0]       ex_o_addr_rd,
    output logic                    ex_o_we,
    output logic [OPCODE_WIDTH-1:0] ex_o_opcode,
    output logic [FUNCT_WIDTH-1:0]  ex_o_funct3,
    output logic                    ex_o_change_pc,
    output logic [PC_WIDTH-1:0]     ex_o_next_pc,
    output logic                    ex_o_stall_req
);

    ex_mem_t             exm_q, exm_d;
    fwd_rec_t            rec_q, rec_d;
    logic                change_pc_q, change_pc_d;
    logic [PC_WIDTH-1:0] next_pc_q, next_pc_d;

    logic                rs1_match, rs2_match;
    logic [DWIDTH-1:0]   rs1_fwd, rs2_fwd;
    logic                stall_req_c;
    logic [DWIDTH-1:0]   op_a, op_b;
    logic [DWIDTH-1:0]   alu_result_c;
    logic                br_taken_c;
    logic                is_branch, is_store;
    logic                ctrl_taken;
    logic [PC_WIDTH-1:0] target_pc;

    logic                capture, bubble, squash, wr_en;
    logic [DWIDTH-1:0]   stage_result;

    // Compare sources against the last writer; a recorded load has no data yet, so it stalls instead
    always_comb begin
        rs1_match   = rec_q.valid && (rec_q.rd != '0) && (rec_q.rd == ex_i_addr_rs1);
        rs2_match   = rec_q.valid && (rec_q.rd != '0) && (rec_q.rd == ex_i_addr_rs2);
        rs1_fwd     = (rs1_match && !rec_q.is_load) ? rec_q.result : ex_i_rs1;
        rs2_fwd     = (rs2_match && !rec_q.is_load) ? rec_q.result : ex_i_rs2;
        stall_req_c = ex_i_valid && rec_q.is_load && (rs1_match || rs2_match);
    end

    assign ex_o_stall_req = stall_req_c;

    // ALU operand selection by opcode
    always_comb begin
        is_branch = (ex_i_opcode == OPC_BRANCH);
        is_store  = (ex_i_opcode == OPC_STORE);
        if ((ex_i_opcode == OPC_AUIPC) || (ex_i_opcode == OPC_JAL)) begin
            op_a = DWIDTH'(ex_i_pc);
        end else if (ex_i_opcode == OPC_LUI) begin
            op_a = '0;
        end else begin
            op_a = rs1_fwd;
        end
        op_b = ((ex_i_opcode == OPC_OP) || is_branch) ? rs2_fwd : ex_i_imm;
    end

    execute_stage_alu_unit u_alu_unit (
        .alu_op     (ex_i_alu),
        .funct3     (ex_i_funct3),
        .op_a       (op_a),
        .op_b       (op_b),
        .result_c   (alu_result_c),
        .br_taken_c (br_taken_c)
    );

    // Control-flow outcome and redirect target
    always_comb begin
        ctrl_taken = (ex_i_opcode == OPC_JAL) || (ex_i_opcode == OPC_JALR)
                     || (is_branch && br_taken_c);
        if (ex_i_opcode == OPC_JALR) begin
            target_pc = PC_WIDTH'(rs1_fwd + ex_i_imm) & ~PC_WIDTH'(1);
        end else begin
            target_pc = ex_i_pc + PC_WIDTH'(ex_i_imm);
        end
    end

    // Next-state for EX/MEM, forwarding record and redirect pulse
    always_comb begin
        exm_d       = exm_q;
        rec_d       = rec_q;
        change_pc_d = 1'b0;
        next_pc_d   = next_pc_q;

        // flush still captures (as a squash) while stalled so a stale instruction cannot linger
        capture      = ex_i_ce && (ex_i_flush || (!ex_i_stall && !stall_req_c));
        bubble       = ex_i_ce && !ex_i_stall && !ex_i_flush && stall_req_c;
        squash       = ex_i_flush || change_pc_q || !ex_i_valid;
        wr_en        = (ex_i_addr_rd != '0) && !is_branch && !is_store;
        stage_result = is_link(ex_i_opcode) ? DWIDTH'(ex_i_pc + PC_WIDTH'(4)) : alu_result_c;

        if (capture) begin
            exm_d.opcode     = ex_i_opcode;
            exm_d.funct3     = ex_i_funct3;
            exm_d.addr_rd    = ex_i_addr_rd;
            exm_d.result     = stage_result;
            exm_d.store_data = rs2_fwd;
            exm_d.valid      = !squash;
            exm_d.we         = !squash && wr_en;
            if (!squash) begin
                change_pc_d = ctrl_taken;
                next_pc_d   = target_pc;
                if (wr_en) begin
                    rec_d = '{valid: 1'b1, is_load: (ex_i_opcode == OPC_LOAD),
                              rd: ex_i_addr_rd, result: stage_result};
                end
            end
        end else if (bubble) begin
            // load moves on to MEM; the re-presented consumer reads the updated register file
            exm_d.valid = 1'b0;
            exm_d.we    = 1'b0;
            rec_d.valid = 1'b0;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge c_clk or posedge c_rst) begin
        if (c_rst) begin
            exm_q       <= '0;
            rec_q       <= '0;
            change_pc_q <= 1'b0;
            next_pc_q   <= '0;
        end else begin
            exm_q       <= exm_d;
            rec_q       <= rec_d;
            change_pc_q <= change_pc_d;
            next_pc_q   <= next_pc_d;
        end
    end

    assign ex_o_valid      = exm_q.valid;
    assign ex_o_result     = exm_q.result;
    assign ex_o_store_data = exm_q.store_data;
    assign ex_o_addr_rd    = exm_q.addr_rd;
    assign ex_o_we         = exm_q.we;
    assign ex_o_opcode     = exm_q.opcode;
    assign ex_o_funct3     = exm_q.funct3;
    assign ex_o_change_pc  = change_pc_q;
    assign ex_o_next_pc    = next_pc_q;

endmodule
